// File: rtl/grn_pkg.sv
// rtl/grn_pkg.sv - shared types and constants for the GRN requestor slice
package grn_pkg;

    localparam int GRN_LINE_W    = 512;
    localparam int GRN_MDATA_W   = 16;
    localparam int GRN_RSP_CNT_W = 32;

    typedef struct packed {
        logic        start;
        logic        finish;
        logic [31:0] num_lines;
    } hc_control_t;

    typedef struct packed {
        logic [41:0] base_addr;
    } hc_buffer_t;

    typedef enum logic [1:0] {
        GRN_IDLE  = 2'd0,
        GRN_RUN   = 2'd1,
        GRN_DRAIN = 2'd2,
        GRN_DONE  = 2'd3
    } grn_wr_state_e;

endpackage

// File: rtl/grn_sync_fifo.sv
// rtl/grn_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
module grn_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/grn_wr_scheduler.sv
// rtl/grn_wr_scheduler.sv - buffers producer result lines and issues them as channel-1 writes
module grn_wr_scheduler
    import grn_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 42
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [31:0]              num_lines,
    input  logic                     req_write,
    input  logic [GRN_LINE_W-1:0]    transient,
    output logic                     ack_write,
    input  logic                     finish,
    input  logic                     c1_almfull,
    output logic                     c1_wr_valid,
    output logic [ADDR_W-1:0]        c1_wr_addr,
    output logic [GRN_LINE_W-1:0]    c1_wr_data,
    output logic [GRN_MDATA_W-1:0]   c1_wr_mdata,
    input  logic                     c1_rsp_valid,
    output logic                     busy,
    output logic                     done,
    output logic [GRN_RSP_CNT_W-1:0] lines_written,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    grn_wr_state_e             state_q;
    grn_wr_state_e             state_d;
    logic [ADDR_W-1:0]         base_q;
    logic [31:0]               num_q;
    logic [31:0]               issue_cnt_q;
    logic                      finish_q;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [GRN_LINE_W-1:0]     fifo_head;

    logic                      start_ok;
    logic                      accept;
    logic                      room;
    logic                      push;
    logic                      pop;
    logic                      finish_seen;
    logic                      rsp_take;

    // A start is only honoured when no run is in flight
    assign start_ok = start && ((state_q == GRN_IDLE) || (state_q == GRN_DONE));

    // ack_write gates acceptance so a held req_write is taken exactly once
    assign accept = (state_q == GRN_RUN) && req_write && !ack_write && !fifo_full;

    // Lines already issued plus lines still queued bound what the run may still take
    assign room = ({1'b0, issue_cnt_q} + 33'(fifo_count)) < {1'b0, num_q};
    assign push = accept && room;
    assign pop  = !fifo_empty && !c1_almfull;

    // A finish arriving this cycle counts immediately so zero-length runs finish fast
    assign finish_seen = finish_q || (finish && (state_q == GRN_RUN));

    // Responses beyond the issued count are stray (e.g. from before a reset)
    assign rsp_take = c1_rsp_valid && (lines_written != issue_cnt_q);

    grn_sync_fifo #(
        .WIDTH (GRN_LINE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_ok),
        .push      (push),
        .push_data (transient),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic for the run sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            GRN_IDLE, GRN_DONE: begin
                if (start_ok) begin
                    state_d = GRN_RUN;
                end
            end
            GRN_RUN: begin
                if (finish_seen && fifo_empty && !accept) begin
                    state_d = GRN_DRAIN;
                end
            end
            GRN_DRAIN: begin
                if (lines_written == issue_cnt_q) begin
                    state_d = GRN_DONE;
                end
            end
            default: state_d = GRN_IDLE;
        endcase
    end

    // State register with registered status flags decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= GRN_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == GRN_RUN) || (state_d == GRN_DRAIN);
            done    <= (state_d == GRN_DONE);
        end
    end

    // Run parameters, counters, finish latch and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q        <= '0;
            num_q         <= '0;
            issue_cnt_q   <= '0;
            lines_written <= '0;
            finish_q      <= 1'b0;
            overflow      <= 1'b0;
            ack_write     <= 1'b0;
        end else begin
            ack_write <= accept;
            if (start_ok) begin
                base_q        <= base_addr;
                num_q         <= num_lines;
                issue_cnt_q   <= '0;
                lines_written <= '0;
                finish_q      <= 1'b0;
                overflow      <= 1'b0;
            end else begin
                if (accept && !room) begin
                    overflow <= 1'b1;
                end
                if (finish && (state_q == GRN_RUN)) begin
                    finish_q <= 1'b1;
                end
                if (pop) begin
                    issue_cnt_q <= issue_cnt_q + 32'd1;
                end
                if (rsp_take) begin
                    lines_written <= lines_written + GRN_RSP_CNT_W'(1);
                end
            end
        end
    end

    // Channel-1 request register; address and mdata derive from the pre-increment issue count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c1_wr_valid <= 1'b0;
            c1_wr_addr  <= '0;
            c1_wr_data  <= '0;
            c1_wr_mdata <= '0;
        end else begin
            c1_wr_valid <= pop;
            if (pop) begin
                c1_wr_addr  <= base_q + ADDR_W'(issue_cnt_q);
                c1_wr_data  <= fifo_head;
                c1_wr_mdata <= issue_cnt_q[GRN_MDATA_W-1:0];
            end
        end
    end

endmodule
